// File: rtl/ysyx_23060240_pkg.sv
// Shared types and constants for the multi-cycle NPC sequencer.
package ysyx_23060240_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_FWAIT = 4'd2,
    S_EXEC  = 4'd3,
    S_MREQ  = 4'd4,
    S_MRSP  = 4'd5,
    S_WB    = 4'd6,
    S_HALT  = 4'd7,
    S_ERR   = 4'd8
  } seq_state_e;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Byte-lane mask of an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_B: return 8'h01;
      MEM_H: return 8'h03;
      MEM_W: return 8'h0F;
      MEM_D: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// Combinational sub-word alignment: store lane shift/strobes and load extract/extend.
module ysyx_23060240_lsu_align
  import ysyx_23060240_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int STRB_W = XLEN / 8,
  localparam int OFFW = $clog2(STRB_W)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFFW-1:0]   byte_off,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rsp_data,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_val
);

  logic [OFFW+2:0] bit_off;
  logic [XLEN-1:0] rsp_shifted;

  // Truncate the lane-aligned word to the access size, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] ext_load(input logic [XLEN-1:0] raw,
                                               input logic [1:0] sz,
                                               input logic zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    res;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (sz)
      MEM_B:   if (zext) res = XLEN'(raw[7:0]);  else res = XLEN'(b);
      MEM_H:   if (zext) res = XLEN'(raw[15:0]); else res = XLEN'(h);
      MEM_W:   if (zext) res = XLEN'(raw[31:0]); else res = XLEN'(w);
      default: res = raw;
    endcase
    return res;
  endfunction

  assign bit_off     = {byte_off, 3'b000};
  assign wstrb       = STRB_W'(size_mask(size)) << byte_off;
  assign wdata       = store_data << bit_off;
  assign rsp_shifted = rsp_data >> bit_off;

  // Load result is fully combinational; the sequencer registers it on the response handshake.
  always_comb begin
    load_val = ext_load(rsp_shifted, size, uns);
  end

endmodule

// File: rtl/ysyx_23060240_mc_seq.sv
// Multi-cycle instruction sequencer: PC, fetch/LSU handshakes, writeback strobe,
// bus timeout, halt and commit reporting. Decode/ALU/regfile remain external.
module ysyx_23060240_mc_seq
  import ysyx_23060240_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  output logic [XLEN-1:0]   ifu_req_addr,
  input  logic              ifu_rsp_valid,
  output logic              ifu_rsp_ready,
  input  logic [31:0]       ifu_rsp_data,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   pc,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic [1:0]        dec_mem_size,
  input  logic              dec_mem_uns,
  input  logic              dec_rd_wen,
  input  logic              dec_is_ebreak,
  input  logic              jump_en,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              lsu_req_valid,
  input  logic              lsu_req_ready,
  output logic              lsu_req_wen,
  output logic [XLEN-1:0]   lsu_req_addr,
  output logic [XLEN-1:0]   lsu_req_wdata,
  output logic [XLEN/8-1:0] lsu_req_wstrb,
  input  logic              lsu_rsp_valid,
  output logic              lsu_rsp_ready,
  input  logic [XLEN-1:0]   lsu_rsp_data,
  output logic [XLEN-1:0]   load_data,
  output logic              rf_wen,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic              halt,
  output logic              bus_err
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFFW   = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [XLEN-1:0]  PC_RST    = XLEN'(RESET_PC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  seq_state_e        state, state_n;
  logic [CNT_W-1:0]  wait_cnt;
  logic              in_wait;
  logic              wait_expired;
  logic              is_mem;
  logic              misaligned;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_load;

  // A 64-bit access can never be legal on a 32-bit datapath.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] low);
    case (size)
      MEM_B: return 1'b0;
      MEM_H: return low[0];
      MEM_W: return low[1:0] != 2'b00;
      MEM_D: return (low != 3'b000) || (XLEN == 32);
    endcase
  endfunction

  ysyx_23060240_lsu_align #(.XLEN(XLEN)) u_align (
    .size       (dec_mem_size),
    .uns        (dec_mem_uns),
    .byte_off   (alu_out[OFFW-1:0]),
    .store_data (rs2_data),
    .rsp_data   (lsu_rsp_data),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_val   (al_load)
  );

  assign is_mem       = dec_is_load | dec_is_store;
  assign misaligned   = addr_misaligned(dec_mem_size, alu_out[2:0]);
  assign in_wait      = (state == S_FETCH) || (state == S_FWAIT) ||
                        (state == S_MREQ)  || (state == S_MRSP);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign halt         = (state == S_HALT);
  assign bus_err      = (state == S_ERR);

  // Next-state and handshake outputs; a handshake wins over a same-cycle timeout.
  always_comb begin
    state_n       = state;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wdata = '0;
    lsu_req_wstrb = '0;
    lsu_rsp_ready = 1'b0;
    rf_wen        = 1'b0;
    commit_valid  = 1'b0;
    commit_pc     = '0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = pc;
        if (ifu_req_ready)     state_n = S_FWAIT;
        else if (wait_expired) state_n = S_ERR;
      end
      S_FWAIT: begin
        ifu_rsp_ready = 1'b1;
        if (ifu_rsp_valid)     state_n = S_EXEC;
        else if (wait_expired) state_n = S_ERR;
      end
      S_EXEC: begin
        if (dec_is_ebreak) begin
          commit_valid = 1'b1;
          commit_pc    = pc;
          state_n      = S_HALT;
        end else if (is_mem && misaligned) begin
          state_n = S_ERR;
        end else if (is_mem) begin
          state_n = S_MREQ;
        end else begin
          state_n = S_WB;
        end
      end
      S_MREQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = dec_is_store;
        lsu_req_addr  = {alu_out[XLEN-1:OFFW], {OFFW{1'b0}}};
        lsu_req_wdata = dec_is_store ? al_wdata : '0;
        lsu_req_wstrb = dec_is_store ? al_wstrb : '0;
        if (lsu_req_ready)     state_n = S_MRSP;
        else if (wait_expired) state_n = S_ERR;
      end
      S_MRSP: begin
        lsu_rsp_ready = 1'b1;
        if (lsu_rsp_valid)     state_n = S_WB;
        else if (wait_expired) state_n = S_ERR;
      end
      S_WB: begin
        rf_wen       = dec_rd_wen;
        commit_valid = 1'b1;
        commit_pc    = pc;
        state_n      = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      S_ERR:  state_n = S_ERR;
      default: state_n = S_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Per-state wait counter: restarts on every transition, counts only in bus-wait states.
  always_ff @(posedge clk) begin
    if (!rst)                  wait_cnt <= '0;
    else if (state_n != state) wait_cnt <= '0;
    else if (in_wait)          wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Instruction latch, load result capture and PC update at writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= PC_RST;
      inst      <= '0;
      load_data <= '0;
    end else begin
      if (state == S_FWAIT && ifu_rsp_valid)
        inst <= ifu_rsp_data;
      if (state == S_MRSP && lsu_rsp_valid && !dec_is_store)
        load_data <= al_load;
      if (state == S_WB)
        pc <= jump_en ? {alu_out[XLEN-1:1], 1'b0} : pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mc_seq.sv
// Directed bench for the multi-cycle sequencer; the bench plays decoder, ALU and both memories.
module tb_ysyx_23060240_mc_seq;
  import ysyx_23060240_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_req_addr, ifu_rsp_data, inst, pc;
  logic        dec_is_load, dec_is_store, dec_mem_uns, dec_rd_wen, dec_is_ebreak, jump_en;
  logic [1:0]  dec_mem_size;
  logic [31:0] alu_out, rs2_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data, load_data, commit_pc;
  logic [3:0]  lsu_req_wstrb;
  logic        rf_wen, commit_valid, halt, bus_err;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_pc;

  ysyx_23060240_mc_seq #(.XLEN(32), .RESET_PC(RST_PC), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .inst(inst), .pc(pc),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_mem_size(dec_mem_size),
    .dec_mem_uns(dec_mem_uns), .dec_rd_wen(dec_rd_wen), .dec_is_ebreak(dec_is_ebreak),
    .jump_en(jump_en), .alu_out(alu_out), .rs2_data(rs2_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .load_data(load_data), .rf_wen(rf_wen), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .halt(halt), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic wen, input logic ebr, input logic jmp,
                         input logic [31:0] alu, input logic [31:0] rs2);
    dec_is_load   = ld;
    dec_is_store  = st;
    dec_mem_size  = sz;
    dec_mem_uns   = uns;
    dec_rd_wen    = wen;
    dec_is_ebreak = ebr;
    jump_en       = jmp;
    alu_out       = alu;
    rs2_data      = rs2;
  endtask

  task automatic wait_commit(input string tag, output int n);
    n = 0;
    while (!commit_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_commit_seen"}, 32'(commit_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!lsu_req_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(lsu_req_valid), 32'd1);
  endtask

  // Hold reset for two edges, check the quiescent outputs, then release into FETCH.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    tick();
    tick();
    check({tag, "_pc"},        pc, RST_PC);
    check({tag, "_ifu_valid"}, 32'(ifu_req_valid), 32'd0);
    check({tag, "_ifu_addr"},  ifu_req_addr, 32'd0);
    check({tag, "_lsu_valid"}, 32'(lsu_req_valid), 32'd0);
    check({tag, "_rsp_ready"}, 32'({ifu_rsp_ready, lsu_rsp_ready}), 32'd0);
    check({tag, "_wb"},        32'({rf_wen, commit_valid}), 32'd0);
    check({tag, "_flags"},     32'({halt, bus_err}), 32'd0);
    check({tag, "_inst"},      inst, 32'd0);
    check({tag, "_load_data"}, load_data, 32'd0);
    rst = 1'b1;
    tick();
    check({tag, "_fetch"}, 32'(ifu_req_valid), 32'd1);
    exp_pc = RST_PC;
  endtask

  // Non-memory instruction from FETCH with zero-wait instruction memory.
  task automatic alu_op(input string tag, input logic jmp, input logic [31:0] tgt,
                        input logic [31:0] iw);
    int n;
    set_dec(1'b0, 1'b0, MEM_W, 1'b0, 1'b1, 1'b0, jmp, tgt, 32'd0);
    ifu_rsp_data  = iw;
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    check({tag, "_addr"}, ifu_req_addr, exp_pc);
    wait_commit(tag, n);
    check({tag, "_lat"},       32'(n), 32'd3);
    check({tag, "_commit_pc"}, commit_pc, exp_pc);
    check({tag, "_rf_wen"},    32'(rf_wen), 32'd1);
    check({tag, "_inst"},      inst, iw);
    tick();
    check({tag, "_pulse"}, 32'({rf_wen, commit_valid}), 32'd0);
    exp_pc = jmp ? {tgt[31:1], 1'b0} : exp_pc + 32'd4;
    check({tag, "_next_pc"}, pc, exp_pc);
  endtask

  // Load/store from FETCH with zero-wait memories; e_val is wdata for stores, load_data for loads.
  task automatic mem_op(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rsp,
                        input logic [3:0] e_strb, input logic [31:0] e_val);
    int n, m;
    set_dec(!st, st, sz, uns, !st, 1'b0, 1'b0, addr, wd);
    lsu_rsp_data  = rsp;
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    wait_req(tag, n);
    check({tag, "_req_lat"},   32'(n), 32'd3);
    check({tag, "_wen"},       32'(lsu_req_wen), 32'(st));
    check({tag, "_lsu_addr"},  lsu_req_addr, {addr[31:2], 2'b00});
    check({tag, "_rsp_early"}, 32'(lsu_rsp_ready), 32'd0);
    if (st) begin
      check({tag, "_wstrb"}, 32'(lsu_req_wstrb), 32'(e_strb));
      check({tag, "_wdata"}, lsu_req_wdata, e_val);
    end
    wait_commit(tag, m);
    check({tag, "_lat"},       32'(n + m), 32'd5);
    check({tag, "_commit_pc"}, commit_pc, exp_pc);
    check({tag, "_rf_wen"},    32'(rf_wen), 32'(!st));
    if (!st) check({tag, "_load_data"}, load_data, e_val);
    tick();
    exp_pc = exp_pc + 32'd4;
    check({tag, "_next_pc"}, pc, exp_pc);
  endtask

  initial begin
    int n;
    int commits;
    int wens;
    logic seen_req, seen_commit, seen_fetch;
    logic [31:0] ebreak_pc;

    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'd0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = 32'd0;
    set_dec(1'b0, 1'b0, MEM_B, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    do_reset("rst0");
    alu_op("addi", 1'b0, 32'h0000_0001, 32'h0010_0093);

    // Fetch request stalled three cycles: request must hold, no progress.
    set_dec(1'b0, 1'b0, MEM_W, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0103, 32'd0);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(ifu_req_valid), 32'd1);
      check("stall_addr",  ifu_req_addr, 32'h8000_0004);
      check("stall_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
      tick();
    end
    check("stall_no_commit", 32'(commit_valid), 32'd0);
    alu_op("jalr", 1'b1, 32'h8000_0103, 32'h0000_80E7);

    mem_op("sb",  1'b1, MEM_B, 1'b0, 32'h8000_0102, 32'h0000_00AB, 32'd0,
           4'b0100, 32'h00AB_0000);
    mem_op("lh",  1'b0, MEM_H, 1'b0, 32'h8000_0002, 32'd0, 32'h8001_1234,
           4'b0000, 32'hFFFF_8001);
    mem_op("lbu", 1'b0, MEM_B, 1'b1, 32'h8000_0003, 32'd0, 32'h8001_1234,
           4'b0000, 32'h0000_0080);
    mem_op("sh",  1'b1, MEM_H, 1'b0, 32'h8000_0022, 32'hCAFE_1234, 32'd0,
           4'b1100, 32'h1234_0000);
    mem_op("lw",  1'b0, MEM_W, 1'b0, 32'h8000_0040, 32'd0, 32'hDEAD_BEEF,
           4'b0000, 32'hDEAD_BEEF);

    // Misaligned word load goes to ERR without touching the data bus.
    set_dec(1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0006, 32'd0);
    seen_req    = 1'b0;
    seen_commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (lsu_req_valid) seen_req = 1'b1;
      if (commit_valid)  seen_commit = 1'b1;
    end
    check("mis_bus_err", 32'(bus_err), 32'd1);
    check("mis_halt",    32'(halt), 32'd0);
    check("mis_state",   32'(dut.state), 32'(S_ERR));
    check("mis_no_req",  32'(seen_req), 32'd0);
    check("mis_no_commit", 32'(seen_commit), 32'd0);
    check("mis_ifu_idle",  32'(ifu_req_valid), 32'd0);
    check("mis_pc",        pc, exp_pc);

    // Reset while a load sits in MRSP with no response coming back.
    do_reset("rst1");
    alu_op("addi2", 1'b0, 32'h0000_0002, 32'h0020_0093);
    set_dec(1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0);
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b0;
    wait_req("hang", n);
    tick();
    check("hang_in_mrsp", 32'(lsu_rsp_ready), 32'd1);
    tick();
    tick();
    do_reset("rst_mrsp");

    // Response never arrives: ERR after MAX_WAIT cycles in MRSP.
    set_dec(1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0);
    wait_req("tmo", n);
    check("tmo_fetch_addr_ok", lsu_req_addr, 32'h8000_0010);
    tick();
    check("tmo_in_mrsp", 32'(lsu_rsp_ready), 32'd1);
    n = 0;
    while (!bus_err && n < 30) begin
      tick();
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd8);
    check("tmo_rsp_ready", 32'(lsu_rsp_ready), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("tmo_sticky", 32'(bus_err), 32'd1);

    // ebreak: exactly one commit, sticky halt, fetch stays quiet.
    do_reset("rst2");
    set_dec(1'b0, 1'b0, MEM_W, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    ifu_rsp_data  = 32'h0010_0073;
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    commits   = 0;
    wens      = 0;
    ebreak_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (commit_valid) begin
        commits++;
        ebreak_pc = commit_pc;
      end
      if (rf_wen) wens++;
    end
    check("ebreak_commits", 32'(commits), 32'd1);
    check("ebreak_pc",      ebreak_pc, RST_PC);
    check("ebreak_no_wen",  32'(wens), 32'd0);
    check("ebreak_halt",    32'(halt), 32'd1);
    seen_fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifu_req_valid) seen_fetch = 1'b1;
      if (commit_valid)  commits++;
    end
    check("ebreak_no_fetch",   32'(seen_fetch), 32'd0);
    check("ebreak_halt_stick", 32'(halt), 32'd1);
    check("ebreak_one_commit", 32'(commits), 32'd1);
    check("ebreak_no_err",     32'(bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
